// File: rtl/div_seq.sv
// div_seq: 32-bit sequential restoring divider, one bit per cycle; signed mode enabled by `define DIV_SIGNED_EN
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t      st, nxt;
  logic [5:0]  cnt;
  logic [31:0] quo, rem, dvs, a_abs, b_abs, q_fix, r_fix, rem_sub;
  logic [32:0] part;
  logic        ge;
  assign part    = {rem, quo[31]};
  assign ge      = part >= {1'b0, dvs};
  assign rem_sub = 32'(part - {1'b0, dvs});
`ifdef DIV_SIGNED_EN
  logic sa, sb, neg_q, neg_r;
  assign sa    = signed_div_i & opdata1_i[31];
  assign sb    = signed_div_i & opdata2_i[31];
  assign a_abs = sa ? -opdata1_i : opdata1_i;
  assign b_abs = sb ? -opdata2_i : opdata2_i;
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;
`else
  logic unused_signed;
  assign unused_signed = signed_div_i;
  assign a_abs = opdata1_i;
  assign b_abs = opdata2_i;
  assign q_fix = quo;
  assign r_fix = rem;
`endif
  // state register
  always_ff @(posedge clk)
    st <= rst ? FREE : nxt;
  // next state: annul wins everywhere, END holds while start stays high
  always_comb begin
    nxt = st;
    nxt = annul_i         ? FREE :
          st == FREE      ? (start_i ? (opdata2_i == '0 ? BYZERO : ON) : FREE) :
          st == BYZERO    ? END :
          st == ON        ? (cnt == 6'd32 ? END : ON) :
          start_i         ? END : FREE;
  end
  // operand latch, shift-subtract steps and registered result
  always_ff @(posedge clk)
    if (rst) begin
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      ready_o  <= 1'b0;
      result_o <= '0;
`ifdef DIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      if (st == FREE && nxt == ON) begin
        cnt <= '0;
        quo <= a_abs;
        rem <= '0;
        dvs <= b_abs;
`ifdef DIV_SIGNED_EN
        neg_q <= sa ^ sb;
        neg_r <= sa;
`endif
      end else if (st == ON && nxt == ON) begin
        cnt <= cnt + 6'd1;
        quo <= {quo[30:0], ge};
        rem <= ge ? rem_sub : part[31:0];
      end
      ready_o  <= nxt == END;
      result_o <= nxt != END ? '0 : st == ON ? {r_fix, q_fix} : st == BYZERO ? '0 : result_o;
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed checks of div_seq latency, results, annul and reset
module tb_div_seq;
  logic        clk = 1'b0, rst = 1'b1, signed_div_i = 1'b0, start_i = 1'b0, annul_i = 1'b0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;
  int          n_cmp = 0, n_bad = 0;
  div_seq dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // count edges from the accept edge until ready_o rises (bounded), scrambling operands after accept
  task automatic wait_ready(input string tag, input int lat);
    int first = 0;
    for (int e = 1; e <= 60 && first == 0; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
      if (ready_o) first = e;
    end
    check({tag, " latency"}, 64'(first), 64'(lat));
  endtask
  // caller is at a negedge; full transaction including hold and release
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic [63:0] exp, input int lat);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sg;
    start_i      = 1'b1;
    wait_ready(tag, lat);
    check({tag, " result"}, result_o, exp);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " release"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask
  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    check("reset", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("u100/7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 34);
    @(negedge clk);
    run_op("u-1/1", 32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF}, 34);
    @(negedge clk);
    run_op("div0", 32'h1234, 32'd0, 1'b0, 64'd0, 2);
`ifdef DIV_SIGNED_EN
    @(negedge clk);
    run_op("s-7/2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
    @(negedge clk);
    run_op("s-100/7", 32'hFFFFFF9C, 32'd7, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, 34);
    @(negedge clk);
    run_op("s100/-7", 32'd100, 32'hFFFFFFF9, 1'b1, {32'h2, 32'hFFFFFFF2}, 34);
    @(negedge clk);
    run_op("sovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 34);
`else
    @(negedge clk);
    run_op("s-7/2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'h1, 32'h7FFFFFFC}, 34);
    @(negedge clk);
    run_op("s-100/7", 32'hFFFFFF9C, 32'd7, 1'b1, {32'h2, 32'h24924916}, 34);
    @(negedge clk);
    run_op("s100/-7", 32'd100, 32'hFFFFFFF9, 1'b1, {32'h64, 32'h0}, 34);
    @(negedge clk);
    run_op("sovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 32'h0}, 34);
`endif
    @(negedge clk);
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd3;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul clear", {63'd0, ready_o} | result_o, 64'd0);
    annul_i = 1'b0;
    seen    = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1;
    end
    check("annul no result", 64'(seen), 64'd0);
    @(negedge clk);
    run_op("u9/4", 32'd9, 32'd4, 1'b0, {32'h1, 32'h2}, 34);
    @(negedge clk);
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst midop", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    rst       = 1'b0;
    wait_ready("rerun", 34);
    check("rerun result", result_o, {32'h2, 32'hE});
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst in end", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    run_op("u8/8", 32'd8, 32'd8, 1'b0, {32'h0, 32'h1}, 34);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port `clk`: input, 1 bit, rising-edge clock.
REQ-003 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `signed_div_i`: input, 1 bit; 1 = signed divide (two's complement), 0 = unsigned.
REQ-005 Port `opdata1_i`: input, 32 bits, dividend; sampled only on the start-accept edge.
REQ-006 Port `opdata2_i`: input, 32 bits, divisor; sampled only on the start-accept edge.
REQ-007 Port `start_i`: input, 1 bit; EX stage requests a divide and holds it high until the result is consumed.
REQ-008 Port `annul_i`: input, 1 bit; pipeline flush, abandons any operation in progress.
REQ-009 Port `result_o`: output, 64 bits; {remainder[63:32], quotient[31:0]}, registered.
REQ-010 Port `ready_o`: output, 1 bit; result_o is valid, registered.

Function
REQ-011 The block SHALL implement four states: FREE, BYZERO, ON, END.
REQ-012 FREE, start_i=1, annul_i=0, divisor==0: next state BYZERO.
REQ-013 FREE, start_i=1, annul_i=0, divisor!=0: next state ON, cnt=0; latch absolute values of the operands when signed, raw values otherwise; latch sign flags.
REQ-014 FREE with start_i=0 or annul_i=1: remain in FREE; ready_o=0; result_o=0.
REQ-015 ON, cnt<32: perform one restoring shift-subtract step (33-bit partial remainder) per cycle; cnt increments by 1.
REQ-016 ON, cnt==32: apply the sign fix-up, load result_o, set ready_o=1, go to END.
REQ-017 Sign fix-up, signed mode only: quotient negated if the operand signs differ; remainder takes the dividend's sign; magnitudes satisfy |R| < |divisor|.
REQ-018 Overflow case 0x80000000 / 0xFFFFFFFF, signed: quotient 0x80000000 (wraps), remainder 0; no trap.
REQ-019 BYZERO: next edge loads result_o=0, ready_o=1, go to END.
REQ-020 END: hold result_o and ready_o while start_i=1.
REQ-021 END with start_i=0: next edge go to FREE, ready_o=0, result_o=0.
REQ-022 annul_i=1 in ON or BYZERO: next edge go to FREE, ready_o=0, result_o=0; no result is produced.
REQ-023 annul_i has priority over all other transitions in every state.
REQ-024 Latency, nonzero divisor: ready_o rises on the 34th rising edge, counting the accept edge as edge 1.
REQ-025 Latency, divide by zero: ready_o rises on the 2nd edge.
REQ-026 Exactly one operation SHALL be in flight at a time.
REQ-027 Operand changes after the accept edge SHALL have no effect on the result.
REQ-028 A new operation is accepted only from FREE.

Reset
REQ-029 When rst=1 at a rising edge: state=FREE, cnt=0, ready_o=0, result_o=0, internal dividend/divisor registers=0.
REQ-030 Reset SHALL take precedence over start_i and annul_i, including mid-operation.
REQ-031 The block SHALL accept start_i on the first edge after rst deasserts.

Configuration
REQ-032 Macro DIV_SIGNED_EN defined: signed division per REQ-013 and REQ-017/018.
REQ-033 Macro DIV_SIGNED_EN undefined: signed_div_i is ignored, all operations are unsigned, and no negation or fix-up logic is synthesized; latency is unchanged.

Verification
REQ-034 Unsigned 100 / 7 -> edge 34: ready_o=1, result_o={0x00000002, 0x0000000E}; held until start_i drops; FREE one edge later.
REQ-035 Signed (macro on) 0xFFFFFFF9 / 2 -> result_o={0xFFFFFFFF, 0xFFFFFFFD}. With the macro off, same stimulus -> {0x00000001, 0x7FFFFFFC}.
REQ-036 Signed 0x80000000 / 0xFFFFFFFF -> result_o={0x00000000, 0x80000000} on edge 34.
REQ-037 Divisor 0, dividend 0x1234 -> edge 2: ready_o=1, result_o=0.
REQ-038 Start 50 / 3, annul_i pulsed at edge 10 -> FREE, ready_o stays 0. Then 9 / 4 -> {0x00000001, 0x00000002} exactly 34 edges after its accept.
REQ-039 rst asserted at edge 20 of an operation -> all outputs 0 next edge. A subsequent 8 / 8 -> {0x00000000, 0x00000001}.
